alu_ctrl_seq: RTL and testbench

- Sequential, parametrised ALU control unit for the MIPS datapath.
- Decodes OpALU/funct into the ALU control code with a valid/ready handshake and a registered output.
- Extends the R-type set with xor, nor, sll, srl, mult and div.
- Sequences the multi-cycle ops (mult/div) with a busy/done counter so the datapath stalls without external timing logic.
- Illegal encodings are flagged explicitly; no X is ever driven.

---
 rtl/alu_ctrl_pkg.sv | 44 ++++
 rtl/alu_ctrl_seq_decode.sv | 60 ++++++
 rtl/alu_ctrl_seq.sv | 110 +++++++++++
 tb/tb_alu_ctrl_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the sequential ALU control unit: ALU codes,
// OpALU/funct constants, FSM state type and small elaboration helpers.
package alu_ctrl_pkg;

  // 4-bit ALU control codes; the top zero-extends them to CTRL_W
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_MULT = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  // OpALU encodings
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_SLT   = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational OpALU/funct decoder. Illegal encodings (including mult/div
// when the multi-cycle unit is disabled) report NOP with illegal set.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ENABLE_MULDIV = 1
) (
  input  logic [1:0] op_alu,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       is_multi,
  output logic       is_div,
  output logic       illegal
);

  // Map the operation selector to an ALU code and multi-cycle flags
  always_comb begin
    code     = ALU_NOP;
    is_multi = 1'b0;
    is_div   = 1'b0;
    illegal  = 1'b0;
    case (op_alu)
      OP_ADD: code = ALU_ADD;
      OP_SUB: code = ALU_SUB;
      OP_SLT: code = ALU_SLT;
      default: begin
        case (funct)
          FN_ADD: code = ALU_ADD;
          FN_SUB: code = ALU_SUB;
          FN_AND: code = ALU_AND;
          FN_OR:  code = ALU_OR;
          FN_XOR: code = ALU_XOR;
          FN_NOR: code = ALU_NOR;
          FN_SLT: code = ALU_SLT;
          FN_SLL: code = ALU_SLL;
          FN_SRL: code = ALU_SRL;
          FN_MULT: begin
            if (ENABLE_MULDIV != 0) begin
              code     = ALU_MULT;
              is_multi = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          FN_DIV: begin
            if (ENABLE_MULDIV != 0) begin
              code     = ALU_DIV;
              is_multi = 1'b1;
              is_div   = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequential ALU control unit: accepts an op on in_valid & in_ready,
// registers the decoded code, and holds off new ops while mult/div run.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W        = 4,
  parameter int MULT_CYCLES   = 4,
  parameter int DIV_CYCLES    = 8,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        OpALU,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              out_valid,
  output logic              illegal_op,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CTRL_W-1:0] NOP_W    = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              out_valid_q, out_valid_d;
  logic              illegal_q, illegal_d;

  logic [3:0] dec_code;
  logic       dec_multi;
  logic       dec_div;
  logic       dec_illegal;
  logic       accept;

  alu_funct_decode #(
    .ENABLE_MULDIV(ENABLE_MULDIV)
  ) u_decode (
    .op_alu  (OpALU),
    .funct   (funct),
    .code    (dec_code),
    .is_multi(dec_multi),
    .is_div  (dec_div),
    .illegal (dec_illegal)
  );

  assign in_ready   = (state_q == IDLE);
  assign accept     = in_valid & in_ready;
  assign busy       = (state_q == BUSY);
  assign done       = (state_q == BUSY) && (cnt_q == '0);
  assign alu_ctrl   = alu_ctrl_q;
  assign out_valid  = out_valid_q;
  assign illegal_op = illegal_q;

  // Next-state, counter and output-register update; outputs hold unless an op is accepted
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_ctrl_d  = alu_ctrl_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          illegal_d   = dec_illegal;
          alu_ctrl_d  = dec_illegal ? NOP_W : CTRL_W'(dec_code);
          if (dec_multi) begin
            state_d = BUSY;
            cnt_d   = dec_div ? DIV_LOAD : MULT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_ctrl_q  <= NOP_W;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_ctrl_q  <= alu_ctrl_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: three configurations driven with shared
// stimulus; a reference decoder plus busy countdown predicts each cycle and
// a per-instance scoreboard queue holds the expected code for every accept.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [1:0] op_alu;
  logic [5:0] funct;

  logic [2:0] rdy, ov, ill, bsy, dn;
  logic [3:0] ctrl0, ctrl1;
  logic [5:0] ctrl2;

  // Instance 0: default configuration
  alu_ctrl_seq u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .OpALU(op_alu), .funct(funct), .alu_ctrl(ctrl0), .out_valid(ov[0]),
    .illegal_op(ill[0]), .busy(bsy[0]), .done(dn[0])
  );

  // Instance 1: multi-cycle ops disabled
  alu_ctrl_seq #(.ENABLE_MULDIV(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .OpALU(op_alu), .funct(funct), .alu_ctrl(ctrl1), .out_valid(ov[1]),
    .illegal_op(ill[1]), .busy(bsy[1]), .done(dn[1])
  );

  // Instance 2: wider code, single-cycle div, two-cycle mult
  alu_ctrl_seq #(.CTRL_W(6), .MULT_CYCLES(2), .DIV_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .OpALU(op_alu), .funct(funct), .alu_ctrl(ctrl2), .out_valid(ov[2]),
    .illegal_op(ill[2]), .busy(bsy[2]), .done(dn[2])
  );

  int n_chk  = 0;
  int n_pass = 0;

  int         cfg_en [3] = '{1, 0, 1};
  int         cfg_mc [3] = '{4, 4, 2};
  int         cfg_dc [3] = '{8, 8, 1};
  logic [7:0] cfg_nop[3] = '{8'h0F, 8'h0F, 8'h3F};

  int         rem  [3];
  logic [7:0] hold [3];
  logic       hill [3];

  logic [8:0] sb0[$];
  logic [8:0] sb1[$];
  logic [8:0] sb2[$];

  logic [5:0] fn_tab[11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h00, 6'h02, 6'h18, 6'h1A};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference decode: {illegal, multi, div, code[3:0]}
  function automatic logic [6:0] ref_decode(input logic [1:0] op, input logic [5:0] f, input int en);
    logic [3:0] c;
    logic m, d, il;
    m = 1'b0; d = 1'b0; il = 1'b0; c = 4'hF;
    if (op == 2'b00)      c = 4'h2;
    else if (op == 2'b01) c = 4'h6;
    else if (op == 2'b11) c = 4'h7;
    else begin
      case (f)
        6'h20: c = 4'h2;
        6'h22: c = 4'h6;
        6'h24: c = 4'h0;
        6'h25: c = 4'h1;
        6'h26: c = 4'h3;
        6'h27: c = 4'hC;
        6'h2A: c = 4'h7;
        6'h00: c = 4'h8;
        6'h02: c = 4'h9;
        6'h18: begin c = 4'hA; m = 1'b1; end
        6'h1A: begin c = 4'hB; m = 1'b1; d = 1'b1; end
        default: begin c = 4'hF; il = 1'b1; end
      endcase
    end
    if (m && en == 0) begin
      il = 1'b1; m = 1'b0; d = 1'b0; c = 4'hF;
    end
    return {il, m, d, c};
  endfunction

  function automatic logic [7:0] get_ctrl(input int k);
    case (k)
      0:       return {4'b0, ctrl0};
      1:       return {4'b0, ctrl1};
      default: return {2'b0, ctrl2};
    endcase
  endfunction

  task automatic sb_push(input int k, input logic [8:0] e);
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sb_pop(input int k, output logic [8:0] e);
    case (k)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  task automatic sb_clear(input int k);
    case (k)
      0:       sb0.delete();
      1:       sb1.delete();
      default: sb2.delete();
    endcase
  endtask

  // One clock: predict accepts, advance on the edge, then compare all instances
  task automatic step();
    logic [2:0] acc;
    logic [6:0] dec;
    logic [7:0] e;
    logic [8:0] ent;
    logic       exp_ov;
    for (int k = 0; k < 3; k++) acc[k] = in_valid && (rem[k] == 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_ov = 1'b0;
      if (rst) begin
        rem[k]  = 0;
        hold[k] = cfg_nop[k];
        hill[k] = 1'b0;
        sb_clear(k);
      end else if (acc[k]) begin
        dec     = ref_decode(op_alu, funct, cfg_en[k]);
        e       = dec[6] ? cfg_nop[k] : {4'b0, dec[3:0]};
        hold[k] = e;
        hill[k] = dec[6];
        exp_ov  = 1'b1;
        sb_push(k, {dec[6], e});
        if (dec[5]) rem[k] = dec[4] ? cfg_dc[k] : cfg_mc[k];
      end else if (rem[k] > 0) begin
        rem[k]--;
      end
      check($sformatf("d%0d_in_ready", k), rdy[k], rem[k] == 0);
      check($sformatf("d%0d_busy", k), bsy[k], rem[k] > 0);
      check($sformatf("d%0d_done", k), dn[k], rem[k] == 1);
      check($sformatf("d%0d_out_valid", k), ov[k], exp_ov);
      check($sformatf("d%0d_alu_ctrl_hold", k), get_ctrl(k), hold[k]);
      check($sformatf("d%0d_illegal_hold", k), ill[k], hill[k]);
      if (ov[k] === 1'b1) begin
        check($sformatf("d%0d_sb_avail", k), sb_size(k), 1);
        if (sb_size(k) > 0) begin
          sb_pop(k, ent);
          check($sformatf("d%0d_sb_alu_ctrl", k), get_ctrl(k), ent[7:0]);
          check($sformatf("d%0d_sb_illegal", k), ill[k], ent[8]);
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
    in_valid = v;
    op_alu   = op;
    funct    = f;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_alu = 2'b00; funct = 6'h00;
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; hold[k] = cfg_nop[k]; hill[k] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
    drive(0, 2'b00, 6'h00);

    // Back-to-back single-cycle ops: add, sub, nor
    drive(1, 2'b00, 6'h00);
    drive(1, 2'b01, 6'h00);
    drive(1, 2'b10, 6'h27);

    // Illegal funct, then a legal add
    drive(1, 2'b10, 6'h3F);
    drive(1, 2'b00, 6'h00);
    drive(0, 2'b00, 6'h00);

    // mult with valid held; follow-on add accepted once busy ends
    drive(1, 2'b10, 6'h18);
    for (int i = 0; i < 6; i++) drive(1, 2'b00, 6'h00);
    drive(0, 2'b00, 6'h00);

    // div, then reset three cycles later in the middle of busy
    drive(1, 2'b10, 6'h1A);
    drive(0, 2'b10, 6'h1A);
    drive(0, 2'b10, 6'h1A);
    rst = 1'b1;
    drive(0, 2'b00, 6'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(0, 2'b00, 6'h00);

    // slt via OpALU=11 with an arbitrary funct
    drive(1, 2'b11, 6'h3F);

    // div with stimulus held across busy periods
    for (int i = 0; i < 12; i++) drive(1, 2'b10, 6'h1A);
    drive(0, 2'b00, 6'h00);

    // Randomised mix with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [5:0] f;
      if ($urandom_range(0, 9) < 7) f = fn_tab[$urandom_range(0, 10)];
      else f = 6'($urandom_range(0, 63));
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), f);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) drive(0, 2'b00, 6'h00);

    for (int k = 0; k < 3; k++) check($sformatf("d%0d_sb_drained", k), sb_size(k), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
